// File: rtl/rp2_bus_pkg.sv
// Shared definitions for the RedBus DMA engine: FSM states, command
// direction encodings, bus widths and the post-yield bus gap.
package rp2_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIR_W  = 2;
    // Remaining-byte counter holds 1..256
    localparam int unsigned CNT_W  = DATA_W + 1;

    // Cycles the bus stays free after the CPU drops BusRelease on a yield
    localparam int unsigned YIELD_GAP = 2;

    localparam logic [DIR_W-1:0] DIR_M2D  = 2'b00;
    localparam logic [DIR_W-1:0] DIR_D2M  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_FILL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_HOLD,
        ST_YIELD,
        ST_DONE
    } dma_state_e;

    // Command context held for the duration of a transfer
    typedef struct packed {
        logic [DIR_W-1:0]  dir;
        logic [ADDR_W-1:0] addr;
    } dma_cmd_t;

    // A length field of zero encodes a full 256-byte block
    function automatic logic [CNT_W-1:0] len_to_count(input logic [DATA_W-1:0] len);
        if (len == '0) begin
            return CNT_W'(256);
        end
        return CNT_W'(len);
    endfunction

endpackage

// File: rtl/dma_byte_counter.sv
// Remaining-byte and per-tenure burst counters for redbus_dma.
// Ports:
//   Clock, Reset   clock, async active-high reset
//   load_i         load remaining count from length_i (0 => 256)
//   length_i       command byte count
//   burst_clr_i    clear burst count at the start of a bus tenure
//   retire_i       one byte completed
//   Last           the byte in flight is the final one
//   BurstEnd       the byte in flight fills the burst to MAX_BURST
module dma_byte_counter
    import rp2_bus_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] length_i,
    input  logic              burst_clr_i,
    input  logic              retire_i,
    output logic              Last,
    output logic              BurstEnd
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    // Next-count selection
    always_comb begin
        remaining_d = remaining_q;
        burst_d     = burst_q;
        if (load_i) begin
            remaining_d = len_to_count(length_i);
        end else if (retire_i) begin
            remaining_d = remaining_q - CNT_W'(1);
        end
        if (burst_clr_i) begin
            burst_d = '0;
        end else if (retire_i) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            remaining_q <= '0;
            burst_q     <= '0;
        end else begin
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
        end
    end

    // Flags describe what happens when the current byte retires
    assign Last     = (remaining_q == CNT_W'(1));
    assign BurstEnd = (burst_q == BURST_W'(MAX_BURST - 1));

endmodule

// File: rtl/redbus_dma.sv
// Bus-mastering DMA engine for the 65EL02 RedBus. Requests the shared
// memory bus, moves bytes between memory and a streaming device port,
// and yields the bus every MAX_BURST bytes so the CPU can fetch.
// Optional feature: define REDBUS_DMA_FILL_EN to enable CmdDir=10 (fill
// memory with CmdFill); otherwise 10 is rejected like 11.
// Ports:
//   Clock, Reset            clock, async active-high reset
//   BusRequest/BusRelease   bus handshake with the CPU
//   Address, Data           shared bus, floated unless this engine owns it
//   DmaReadMem/DmaWriteMem  memory strobes (ORed with the CPU's at top level)
//   Cmd*                    command: start, direction, address, length, fill
//   CmdBusy, CmdDone        busy level and completion pulse
//   DevRd*                  device->memory byte stream (valid/ready)
//   DevWr*                  memory->device byte stream (valid/ready)
module redbus_dma
    import rp2_bus_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              BusRequest,
    input  logic              BusRelease,
    output wire  [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    output logic              DmaReadMem,
    output logic              DmaWriteMem,
    input  logic              CmdStart,
    input  logic [DIR_W-1:0]  CmdDir,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic [DATA_W-1:0] CmdLength,
    input  logic [DATA_W-1:0] CmdFill,
    output logic              CmdBusy,
    output logic              CmdDone,
    input  logic [DATA_W-1:0] DevRdData,
    input  logic              DevRdValid,
    output logic              DevRdReady,
    output logic [DATA_W-1:0] DevWrData,
    output logic              DevWrValid,
    input  logic              DevWrReady
);

    localparam int unsigned GAP_W = $clog2(YIELD_GAP + 1);

    dma_state_e        state_q, state_d;
    dma_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              held_q, held_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              cmd_legal;
    logic              cnt_load;
    logic              burst_clr;
    logic              retire;
    logic              last;
    logic              burst_end;
    dma_state_e        byte_state;
    dma_state_e        retire_state;
    logic [DATA_W-1:0] wr_byte;

    dma_byte_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_counter (
        .Clock       (Clock),
        .Reset       (Reset),
        .load_i      (cnt_load),
        .length_i    (CmdLength),
        .burst_clr_i (burst_clr),
        .retire_i    (retire),
        .Last        (last),
        .BurstEnd    (burst_end)
    );

    // Direction legality; fill only exists when the feature is built in
    always_comb begin
        cmd_legal = (CmdDir == DIR_M2D) || (CmdDir == DIR_D2M);
`ifdef REDBUS_DMA_FILL_EN
        if (CmdDir == DIR_FILL) begin
            cmd_legal = 1'b1;
        end
`endif
    end

`ifdef REDBUS_DMA_FILL_EN
    logic [DATA_W-1:0] fill_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fill_q <= '0;
        end else if (state_q == ST_IDLE && CmdStart && cmd_legal) begin
            fill_q <= CmdFill;
        end
    end

    assign wr_byte = (cmd_q.dir == DIR_FILL) ? fill_q : data_q;
`else
    logic unused_fill;
    assign unused_fill = ^CmdFill;
    assign wr_byte     = data_q;
`endif

    // Where to go after a byte retires
    always_comb begin
        if (cmd_q.dir == DIR_M2D) begin
            byte_state = ST_READ;
        end else if (cmd_q.dir == DIR_D2M) begin
            byte_state = ST_HOLD;
        end else begin
            byte_state = ST_WRITE;
        end
        if (last) begin
            retire_state = ST_DONE;
        end else if (burst_end) begin
            retire_state = ST_YIELD;
        end else begin
            retire_state = byte_state;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        held_d    = held_q;
        gap_d     = gap_q;
        cnt_load  = 1'b0;
        burst_clr = 1'b0;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CmdStart && cmd_legal) begin
                    cmd_d.dir  = CmdDir;
                    cmd_d.addr = CmdAddr;
                    held_d     = 1'b0;
                    cnt_load   = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (BusRelease) begin
                    burst_clr = 1'b1;
                    if (cmd_q.dir == DIR_M2D) begin
                        state_d = ST_READ;
                    end else if (cmd_q.dir == DIR_D2M && !held_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Fill, or a device byte already taken whose write was aborted
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (!BusRelease) begin
                    state_d = ST_REQ;
                end else begin
                    data_d  = Data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cmd_q.dir == DIR_M2D) begin
                    if (DevWrReady) begin
                        retire  = 1'b1;
                        state_d = retire_state;
                    end
                end else if (DevRdValid) begin
                    data_d  = DevRdData;
                    held_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!BusRelease) begin
                    state_d = ST_REQ;
                end else begin
                    retire  = 1'b1;
                    held_d  = 1'b0;
                    state_d = retire_state;
                end
            end
            ST_YIELD: begin
                // Start counting once the CPU has taken the bus back
                if (gap_q != '0 || !BusRelease) begin
                    if (gap_q == GAP_W'(YIELD_GAP)) begin
                        gap_d   = '0;
                        state_d = ST_REQ;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire) begin
            cmd_d.addr = cmd_q.addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            held_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            held_q  <= held_d;
            gap_q   <= gap_d;
        end
    end

    // Bus drive: only while granted and in a memory cycle
    assign DmaReadMem  = BusRelease && (state_q == ST_READ);
    assign DmaWriteMem = BusRelease && (state_q == ST_WRITE);
    assign Address     = (DmaReadMem || DmaWriteMem) ? cmd_q.addr : {ADDR_W{1'bz}};
    assign Data        = DmaWriteMem ? wr_byte : {DATA_W{1'bz}};

    assign BusRequest  = (state_q == ST_REQ) || (state_q == ST_READ) ||
                         (state_q == ST_HOLD) || (state_q == ST_WRITE);
    assign CmdBusy     = (state_q != ST_IDLE);
    assign CmdDone     = (state_q == ST_DONE);
    assign DevRdReady  = (state_q == ST_HOLD) && (cmd_q.dir == DIR_D2M);
    assign DevWrValid  = (state_q == ST_HOLD) && (cmd_q.dir == DIR_M2D);
    assign DevWrData   = data_q;

endmodule

// File: tb/tb_redbus_dma.sv
// Directed self-checking bench for redbus_dma: CPU grant model, byte-wide
// memory, device source/sink, and hand-computed expectations.
module tb_redbus_dma;
    import rp2_bus_pkg::*;

    localparam int unsigned MAX_BURST = 16;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        BusRequest;
    logic        BusRelease = 1'b0;
    wire  [15:0] Address;
    wire  [7:0]  Data;
    logic        DmaReadMem;
    logic        DmaWriteMem;
    logic        CmdStart = 1'b0;
    logic [1:0]  CmdDir = 2'b00;
    logic [15:0] CmdAddr = 16'h0000;
    logic [7:0]  CmdLength = 8'h00;
    logic [7:0]  CmdFill = 8'h00;
    logic        CmdBusy;
    logic        CmdDone;
    logic [7:0]  DevRdData = 8'h00;
    logic        DevRdValid = 1'b0;
    logic        DevRdReady;
    logic [7:0]  DevWrData;
    logic        DevWrValid;
    logic        DevWrReady = 1'b0;

    redbus_dma #(.MAX_BURST(MAX_BURST)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .BusRequest  (BusRequest),
        .BusRelease  (BusRelease),
        .Address     (Address),
        .Data        (Data),
        .DmaReadMem  (DmaReadMem),
        .DmaWriteMem (DmaWriteMem),
        .CmdStart    (CmdStart),
        .CmdDir      (CmdDir),
        .CmdAddr     (CmdAddr),
        .CmdLength   (CmdLength),
        .CmdFill     (CmdFill),
        .CmdBusy     (CmdBusy),
        .CmdDone     (CmdDone),
        .DevRdData   (DevRdData),
        .DevRdValid  (DevRdValid),
        .DevRdReady  (DevRdReady),
        .DevWrData   (DevWrData),
        .DevWrValid  (DevWrValid),
        .DevWrReady  (DevWrReady)
    );

    // Memory model: drives Data during DMA reads, captures writes below
    logic [7:0]  mem [0:65535];
    logic [7:0]  mem_rd;
    assign mem_rd = mem[Address];
    assign Data   = DmaReadMem ? mem_rd : 8'hzz;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          grant_dly   = 3;
    int          req_cnt     = 0;
    logic        wr_ready_en = 1'b1;
    logic [7:0]  src [$];
    int          src_idx = 0;
    logic [7:0]  rx [$];
    logic [15:0] wr_addr [$];
    int          wr_cyc [$];
    logic [15:0] rd_addr [$];
    int          cyc      = 0;
    int          done_cnt = 0;
    int          tenures  = 0;
    int          run      = 0;
    int          min_gap  = 1000;
    logic        prev_rel = 1'b0;

    initial begin
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment: drive inputs on negedge, sample handshakes 1ns later
    initial begin
        forever begin
            @(negedge Clock);
            if (!BusRequest) begin
                BusRelease = 1'b0;
                req_cnt    = 0;
            end else if (!BusRelease) begin
                if (req_cnt >= grant_dly) BusRelease = 1'b1;
                else req_cnt++;
            end
            DevWrReady = wr_ready_en;
            DevRdValid = (src_idx < src.size());
            DevRdData  = DevRdValid ? src[src_idx] : 8'h00;
            #1;
            cyc++;
            if (DmaWriteMem) begin
                mem[Address] = Data;
                wr_addr.push_back(Address);
                wr_cyc.push_back(cyc);
            end
            if (DmaReadMem) rd_addr.push_back(Address);
            if (DevWrValid && DevWrReady) rx.push_back(DevWrData);
            if (DevRdValid && DevRdReady) src_idx++;
            if (CmdDone) done_cnt++;
            if (BusRelease && !prev_rel) tenures++;
            prev_rel = BusRelease;
            if (!CmdBusy) begin
                run = 0;
            end else if (!BusRequest && !BusRelease) begin
                run++;
            end else if (BusRequest && run > 0) begin
                if (run < min_gap) min_gap = run;
                run = 0;
            end
        end
    end

    task automatic start_cmd(input logic [1:0] dir, input logic [15:0] addr,
                             input logic [7:0] len, input logic [7:0] fill);
        @(negedge Clock);
        CmdDir    = dir;
        CmdAddr   = addr;
        CmdLength = len;
        CmdFill   = fill;
        CmdStart  = 1'b1;
        @(negedge Clock);
        CmdStart  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            #2;
            if (done_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busreq"}, 32'(BusRequest), 32'd0);
        check({tag, "_rdstb"},  32'(DmaReadMem), 32'd0);
        check({tag, "_wrstb"},  32'(DmaWriteMem), 32'd0);
        check({tag, "_busy"},   32'(CmdBusy), 32'd0);
        check({tag, "_done"},   32'(CmdDone), 32'd0);
        check({tag, "_rdrdy"},  32'(DevRdReady), 32'd0);
        check({tag, "_wrvld"},  32'(DevWrValid), 32'd0);
        check({tag, "_wrdata"}, 32'(DevWrData), 32'd0);
    endtask

    initial begin
        int          base;
        int          bad;
        bit          seen;
        logic [15:0] exp_a [4];
        logic [7:0]  exp_b [4];

        // Reset state
        repeat (3) @(negedge Clock);
        #1;
        check_reset_outputs("rst");
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // mem->dev, 4 bytes from 0x0400, grant after 3 cycles
        mem[16'h0400] = 8'h11; mem[16'h0401] = 8'h22;
        mem[16'h0402] = 8'h33; mem[16'h0403] = 8'h44;
        grant_dly = 3;
        rx.delete();
        base = done_cnt;
        start_cmd(DIR_M2D, 16'h0400, 8'd4, 8'h00);
        #2;
        check("t1_req_latency", 32'(BusRequest), 32'd1);
        check("t1_busy", 32'(CmdBusy), 32'd1);
        wait_done("t1_done", 200);
        repeat (5) @(negedge Clock);
        #2;
        check("t1_done_once", 32'(done_cnt - base), 32'd1);
        check("t1_req_low", 32'(BusRequest), 32'd0);
        check("t1_busy_low", 32'(CmdBusy), 32'd0);
        check("t1_rx_count", 32'(rx.size()), 32'd4);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            if (i < rx.size()) check($sformatf("t1_rx%0d", i), 32'(rx[i]), 32'(exp_b[i]));
        end

        // dev->mem, 256 bytes at 0x8000, 16-byte bursts
        src.delete();
        for (int i = 0; i < 256; i++) begin
            src.push_back(8'(i * 7 + 3));
            mem[16'h8000 + 16'(i)] = 8'h00;
        end
        src_idx   = 0;
        grant_dly = 1;
        tenures   = 0;
        min_gap   = 1000;
        wr_addr.delete();
        base = done_cnt;
        start_cmd(DIR_D2M, 16'h8000, 8'd0, 8'h00);
        wait_done("t2_done", 3000);
        repeat (3) @(negedge Clock);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[16'h8000 + 16'(i)] !== 8'(i * 7 + 3)) bad++;
        end
        check("t2_mem_bad", 32'(bad), 32'd0);
        check("t2_writes", 32'(wr_addr.size()), 32'd256);
        check("t2_src_taken", 32'(src_idx), 32'd256);
        check("t2_tenures", 32'(tenures), 32'd16);
        check("t2_min_gap", 32'(min_gap), 32'd3);
        check("t2_done_once", 32'(done_cnt - base), 32'd1);

        // Address wrap FFFE..0001
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h00;
        src.delete();
        src.push_back(8'hC1); src.push_back(8'hC2);
        src.push_back(8'hC3); src.push_back(8'hC4);
        src_idx   = 0;
        grant_dly = 2;
        wr_addr.delete();
        start_cmd(DIR_D2M, 16'hFFFE, 8'd4, 8'h00);
        wait_done("t3_done", 200);
        check("t3_writes", 32'(wr_addr.size()), 32'd4);
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr.size()) check($sformatf("t3_addr%0d", i), 32'(wr_addr[i]), 32'(exp_a[i]));
            check($sformatf("t3_mem%0d", i), 32'(mem[exp_a[i]]), 32'(exp_b[i]));
        end

        // Device stall mid-burst on mem->dev
        mem[16'h0500] = 8'h51; mem[16'h0501] = 8'h52;
        mem[16'h0502] = 8'h53; mem[16'h0503] = 8'h54;
        rx.delete();
        rd_addr.delete();
        wr_ready_en = 1'b1;
        start_cmd(DIR_M2D, 16'h0500, 8'd4, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            #2;
            if (rx.size() >= 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_first_byte", 32'(seen), 32'd1);
        wr_ready_en = 1'b0;
        repeat (2) @(negedge Clock);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            #2;
            if (DevWrData !== 8'h52 || DevWrValid !== 1'b1 || BusRequest !== 1'b1 ||
                rd_addr.size() != 2) bad++;
        end
        check("t4_stall_hold", 32'(bad), 32'd0);
        wr_ready_en = 1'b1;
        wait_done("t4_done", 200);
        check("t4_reads", 32'(rd_addr.size()), 32'd4);
        check("t4_rx_count", 32'(rx.size()), 32'd4);
        exp_b = '{8'h51, 8'h52, 8'h53, 8'h54};
        for (int i = 0; i < 4; i++) begin
            if (i < rd_addr.size()) check($sformatf("t4_rdaddr%0d", i), 32'(rd_addr[i]), 32'(16'h0500 + 16'(i)));
            if (i < rx.size()) check($sformatf("t4_rx%0d", i), 32'(rx[i]), 32'(exp_b[i]));
        end

        // Reset mid-burst
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(8'(8'h60 + i));
        src_idx   = 0;
        grant_dly = 1;
        wr_addr.delete();
        start_cmd(DIR_D2M, 16'h3000, 8'd8, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            #2;
            if (wr_addr.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_started", 32'(seen), 32'd1);
        base = done_cnt;
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge Clock);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        #2;
        check("t5_no_done", 32'(done_cnt - base), 32'd0);
        check("t5_idle", 32'(CmdBusy), 32'd0);
        check("t5_busreq", 32'(BusRequest), 32'd0);

        // Fill: enabled -> three back-to-back writes, disabled -> rejected
        mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h00; mem[16'h2002] = 8'h00;
        wr_addr.delete();
        wr_cyc.delete();
        grant_dly = 2;
        start_cmd(DIR_FILL, 16'h2000, 8'd3, 8'hA5);
        #2;
`ifdef REDBUS_DMA_FILL_EN
        check("t6_busy", 32'(CmdBusy), 32'd1);
        wait_done("t6_done", 200);
        check("t6_writes", 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr.size()) check($sformatf("t6_addr%0d", i), 32'(wr_addr[i]), 32'(16'h2000 + 16'(i)));
            check($sformatf("t6_mem%0d", i), 32'(mem[16'h2000 + 16'(i)]), 32'h0000_00A5);
        end
        if (wr_cyc.size() == 3) check("t6_back_to_back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
`else
        check("t6_busy", 32'(CmdBusy), 32'd0);
        repeat (10) @(negedge Clock);
        #2;
        check("t6_writes", 32'(wr_addr.size()), 32'd0);
        check("t6_mem", 32'(mem[16'h2000]), 32'd0);
`endif

        // Reserved direction is ignored
        repeat (3) @(negedge Clock);
        start_cmd(2'b11, 16'h1000, 8'd2, 8'h00);
        #2;
        check("t7_busy", 32'(CmdBusy), 32'd0);
        check("t7_busreq", 32'(BusRequest), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
